bu_array_pipe: RTL
==================

// Module: bu_array_pipe
// PURPOSE
//  NUM_BU parallel NTT/INTT butterflies over Z_Q (Q=8380417), fully pipelined with valid/ready
//  handshake. Mode (CT/GS) and halving are per beat, so NTT and INTT layers stream back to back
//  without a flush. Sits between the coefficient-memory read path and the write-back path of the NTT core.
// PARAMETERS
//  NUM_BU   4   butterflies per beat (lanes); all lanes share one handshake
//  DATA_W   32  coefficient/twiddle width; inputs are canonical, in [0,Q)
//  TAG_W    8   sideband (write address) carried alongside each beat, unmodified
// PORTS
//  clk_i      in   1               single clock, rising edge
//  rst_i      in   1               synchronous, active-high reset
//  in_valid   in   1               beat offered
//  in_ready   out  1               beat accepted when in_valid & in_ready
//  in_mode    in   1               0 = CT (NTT), 1 = GS (INTT)
//  in_halve   in   1               GS only: scale both outputs by 2^-1 mod Q; ignored in CT
//  in_u       in   NUM_BU*DATA_W   u operands, lane k at [k*DATA_W +: DATA_W]
//  in_t       in   NUM_BU*DATA_W   t operands
//  in_w       in   NUM_BU*DATA_W   twiddles, Montgomery form (w*2^32 mod Q)
//  in_tag     in   TAG_W           sideband
//  out_valid  out  1               result beat present
//  out_ready  in   1               downstream accepts
//  out_u      out  NUM_BU*DATA_W   u results, in [0,Q)
//  out_t      out  NUM_BU*DATA_W   t results, in [0,Q)
//  out_tag    out  TAG_W           in_tag of the same beat
//  busy       out  1               any pipeline stage holds a valid beat
// BEHAVIOUR
//  Arithmetic per lane (mr(x) = x*2^-32 mod Q, 64-bit signed product, result in [0,Q)):
//   CT: p = mr(t*w); u' = (u+p) mod Q; t' = (u-p) mod Q
//   GS: u' = (u+t) mod Q; t' = mr(((u-t) mod Q)*w); halve: x -> x even ? x>>1 : (x+Q)>>1
//   Every add/sub is fully reduced to [0,Q) with one conditional +/-Q; no lazy reduction.
//  Pipeline: S1 input register | S2 CT multiply, GS add/sub | S3 Montgomery reduction |
//   S4 CT add/sub, GS halve -> output register. Latency 4 cycles from acceptance to out_valid
//   with out_ready held high; throughput 1 beat/cycle.
//  Stall: en = !out_valid | out_ready; in_ready = en; all stages advance only when en.
//   Valid bits advance with data, so bubbles are carried through, not collapsed.
//   While out_valid & !out_ready, out_* and out_tag hold stable and in_ready = 0.
//  Per-beat mode/halve/tag travel with the beat; mixed CT/GS beats in flight are legal.
//  Reset: all stage valids, out_valid, busy, out_u, out_t and out_tag = 0; in_ready = 1
//   from the first cycle after reset. Reset mid-stream discards every in-flight beat, with no
//   partial output. Reset has priority over a simultaneous handshake.
//  in_ready is a function of out_valid/out_ready only, never of in_valid (no comb loop upstream).
//  Inputs >= Q are undefined behaviour. The bench's scoreboard flags them; RTL does not check.
// STRUCTURE
//  ntt_pkg: Q=8380417, QINV=58728449 (Q^-1 mod 2^32), MONT=4193792 (2^32 mod Q),
//   typedef enum logic {BU_CT, BU_GS} bu_mode_e, function mod_add/mod_sub/mod_half.
//  Sub-module ntt_mont_red: combinational 64->32 Montgomery reduction with canonical output.
//   Instantiated once per lane in S3.
//  Lanes via generate loop. The control pipeline (valid/mode/halve/tag) is shared across lanes.
// TESTING
//  CT, w=MONT, u=5, t=3 -> 4 cycles later out_u=8, out_t=2 in all lanes, tag echoed.
//  CT wrap: u=Q-1, t=2, w=MONT -> out_u=1, out_t=8380414.
//  GS no halve: u=0, t=1, w=MONT -> out_u=1, out_t=8380416. Same with halve -> out_u=4190209, out_t=4190208.
//  Alternate CT/GS beats every cycle, random values, out_ready random 50% -> ordered output
//   matches the model, no loss or duplication, outputs stable while stalled, in_ready low only when stalled.
//  Fill 3 beats, assert rst_i for 1 cycle -> out_valid=0, busy=0, outputs 0, in_ready=1 next cycle.
//   No stale beat ever appears afterwards.
//  Random w in Montgomery form, 10^5 beats vs golden model (CT then GS+halve, twiddles inverse
//   and /2 per layer) -> every coefficient matches, all outputs < Q.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - modulus constants, butterfly mode and modular helpers for the NTT core
//   Q     : prime modulus 8380417
//   QINV  : Q^-1 mod 2^32, used by the Montgomery reduction
//   MONT  : 2^32 mod Q, Montgomery form of 1
//   mod_add / mod_sub / mod_half operate on canonical values in [0,Q)
package ntt_pkg;

   localparam logic [31:0] Q    = 32'd8380417;
   localparam logic [31:0] QINV = 32'd58728449;
   localparam logic [31:0] MONT = 32'd4193792;

   typedef enum logic {BU_CT = 1'b0, BU_GS = 1'b1} bu_mode_e;

   function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, Q}) s = s - {1'b0, Q};
      return s[31:0];
   endfunction

   // A borrow out of the 33-bit difference marks a negative result; adding Q
   // modulo 2^33 lands it back in [0,Q).
   function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[32]) d = d + {1'b0, Q};
      return d[31:0];
   endfunction

   // Multiply by 2^-1 mod Q: odd values become even by adding the (odd) modulus.
   function automatic logic [31:0] mod_half(input logic [31:0] a);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, Q};
      return a[0] ? s[32:1] : {1'b0, a[31:1]};
   endfunction

endpackage

// File: rtl/ntt_mont_red.sv
// rtl/ntt_mont_red.sv - combinational 64->32 Montgomery reduction, canonical output
//   x : product to reduce (non-negative, below Q^2 in this core)
//   r : x * 2^-32 mod Q, in [0,Q)
module ntt_mont_red
   import ntt_pkg::*;
(
   input  logic [63:0] x,
   output logic [31:0] r
);

   logic [31:0] m;
   logic [63:0] mq;
   logic [63:0] diff;
   logic [31:0] hi;
   logic        unused_lo;

   // m is chosen so that x - m*Q is a multiple of 2^32; the upper word of that
   // difference is a signed value in (-Q,Q), folded to [0,Q) with one +Q.
   always_comb begin
      m    = x[31:0] * QINV;
      mq   = {32'd0, m} * {32'd0, Q};
      diff = x - mq;
      hi   = diff[63:32];
      r    = hi[31] ? hi + Q : hi;
   end

   // Lower word is zero by construction.
   assign unused_lo = ^diff[31:0];

endmodule

// File: rtl/bu_array_pipe.sv
// rtl/bu_array_pipe.sv - NUM_BU parallel CT/GS butterflies over Z_Q, 4-stage stallable pipeline
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid / in_ready   : input beat handshake (in_ready depends only on the output side)
//   in_mode, in_halve     : per-beat butterfly type (0 CT, 1 GS) and GS scaling by 1/2
//   in_u, in_t, in_w      : lane operands, lane k at [k*DATA_W +: DATA_W], w in Montgomery form
//   in_tag                : sideband carried unmodified with the beat
//   out_valid / out_ready : output beat handshake
//   out_u, out_t, out_tag : lane results in [0,Q) and the beat's tag
//   busy                  : some stage holds a valid beat
module bu_array_pipe
   import ntt_pkg::*;
#(
   parameter int NUM_BU = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mode,
   input  logic                     in_halve,
   input  logic [NUM_BU*DATA_W-1:0] in_u,
   input  logic [NUM_BU*DATA_W-1:0] in_t,
   input  logic [NUM_BU*DATA_W-1:0] in_w,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_BU*DATA_W-1:0] out_u,
   output logic [NUM_BU*DATA_W-1:0] out_t,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     busy
);

   logic             en;
   logic             v1, v2, v3;
   bu_mode_e         mode1, mode2, mode3;
   logic             halve1, halve2, halve3;
   logic [TAG_W-1:0] tag1, tag2, tag3;

   // Whole pipe moves as one; a held output freezes every stage, bubbles included.
   assign en       = !out_valid | out_ready;
   assign in_ready = en;
   assign busy     = v1 | v2 | v3 | out_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         out_tag   <= '0;
      end else if (en) begin
         v1        <= in_valid;
         mode1     <= bu_mode_e'(in_mode);
         halve1    <= in_halve;
         tag1      <= in_tag;
         v2        <= v1;
         mode2     <= mode1;
         halve2    <= halve1;
         tag2      <= tag1;
         v3        <= v2;
         mode3     <= mode2;
         halve3    <= halve2;
         tag3      <= tag2;
         out_valid <= v3;
         out_tag   <= tag3;
      end
   end

   for (genvar k = 0; k < NUM_BU; k++) begin : g_lane
      logic [DATA_W-1:0]   u1, t1, w1;
      logic [DATA_W-1:0]   a2, a2_d;
      logic [2*DATA_W-1:0] p2, p2_d;
      logic [DATA_W-1:0]   a3, r3, red;
      logic [DATA_W-1:0]   ou, ot, ou_d, ot_d;

      // S2: CT multiplies t*w; GS forms u+t and multiplies (u-t)*w.
      always_comb begin
         a2_d = u1;
         p2_d = {{DATA_W{1'b0}}, t1} * {{DATA_W{1'b0}}, w1};
         if (mode1 == BU_GS) begin
            a2_d = mod_add(u1, t1);
            p2_d = {{DATA_W{1'b0}}, mod_sub(u1, t1)} * {{DATA_W{1'b0}}, w1};
         end
      end

      // S3 reduction of the registered product.
      ntt_mont_red u_red (
         .x (p2),
         .r (red)
      );

      // S4: CT combines u with the reduced product; GS optionally halves both.
      always_comb begin
         ou_d = a3;
         ot_d = r3;
         if (mode3 == BU_CT) begin
            ou_d = mod_add(a3, r3);
            ot_d = mod_sub(a3, r3);
         end else if (halve3) begin
            ou_d = mod_half(a3);
            ot_d = mod_half(r3);
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            ou <= '0;
            ot <= '0;
         end else if (en) begin
            u1 <= in_u[k*DATA_W +: DATA_W];
            t1 <= in_t[k*DATA_W +: DATA_W];
            w1 <= in_w[k*DATA_W +: DATA_W];
            a2 <= a2_d;
            p2 <= p2_d;
            a3 <= a2;
            r3 <= red;
            ou <= ou_d;
            ot <= ot_d;
         end
      end

      assign out_u[k*DATA_W +: DATA_W] = ou;
      assign out_t[k*DATA_W +: DATA_W] = ot;
   end

endmodule
